// File: rtl/iq_norm_pipe.sv
// rtl/iq_norm_pipe.sv - multi-lane I/Q offset/gain normaliser, 5-stage fixed-latency pipeline
// Optional saturation counter: define IQ_NORM_SAT_COUNT_EN to add sat_count/sat_clr.
module iq_norm_pipe #(
  parameter int N_CH   = 1,
  parameter int IN_W   = 32,
  parameter int OUT_W  = 18,
  parameter int COEF_W = 18,
  parameter int SHIFT  = 16,
  parameter int AW     = ($clog2(2 * N_CH) < 1) ? 1 : $clog2(2 * N_CH)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  input  logic [2*N_CH*IN_W-1:0]    in_data,
  input  logic                      stb_start,
  output logic                      out_valid,
  output logic [2*N_CH*OUT_W-1:0]   out_data,
  output logic                      NN_startTrigger,
  input  logic                      cfg_we,
  input  logic                      cfg_sel,
  input  logic [AW-1:0]             cfg_lane,
  input  logic [IN_W-1:0]           cfg_data,
  input  logic                      cfg_commit,
  output logic                      cfg_pending
`ifdef IQ_NORM_SAT_COUNT_EN
  ,
  output logic [15:0]               sat_count,
  input  logic                      sat_clr
`endif
);

  localparam int L  = 2 * N_CH;
  localparam int SW = IN_W + 1;
  localparam int PW = IN_W + 1 + COEF_W;

  localparam logic signed [PW-1:0]     RND_HALF = {{(PW-1){1'b0}}, 1'b1} << (SHIFT - 1);
  localparam logic signed [PW-1:0]     MAXV     = {{(PW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [PW-1:0]     MINV     = {{(PW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
  localparam logic signed [COEF_W-1:0] GAIN_ONE = COEF_W'(1) << SHIFT;

  typedef enum logic {IDLE, PENDING} state_t;

  // Per-stage data; index 0 of vld/stb is S1, index 4 is S5.
  logic signed [IN_W-1:0]   x1_q    [L];
  logic signed [IN_W-1:0]   x1_d    [L];
  logic signed [SW-1:0]     sum2_q  [L];
  logic signed [SW-1:0]     sum2_d  [L];
  logic signed [PW-1:0]     prod3_q [L];
  logic signed [PW-1:0]     prod3_d [L];
  logic signed [PW-1:0]     rnd4_q  [L];
  logic signed [PW-1:0]     rnd4_d  [L];
  logic signed [OUT_W-1:0]  y5_q    [L];
  logic signed [OUT_W-1:0]  y5_d    [L];
  logic [4:0]               vld_q, vld_d;
  logic [4:0]               stb_q, stb_d;

  logic signed [IN_W-1:0]   off_sh_q  [L];
  logic signed [IN_W-1:0]   off_sh_d  [L];
  logic signed [IN_W-1:0]   off_act_q [L];
  logic signed [IN_W-1:0]   off_act_d [L];
  logic signed [COEF_W-1:0] gn_sh_q   [L];
  logic signed [COEF_W-1:0] gn_sh_d   [L];
  logic signed [COEF_W-1:0] gn_act_q  [L];
  logic signed [COEF_W-1:0] gn_act_d  [L];

  state_t state_q, state_d;
  logic   pipe_idle;
  logic   do_copy;

  // Datapath: offset add, gain multiply, round half up, saturate; S5 holds when idle.
  always_comb begin
    for (int l = 0; l < L; l++) begin
      x1_d[l]    = in_data[l*IN_W +: IN_W];
      sum2_d[l]  = {x1_q[l][IN_W-1], x1_q[l]} + {off_act_q[l][IN_W-1], off_act_q[l]};
      prod3_d[l] = PW'(sum2_q[l]) * PW'(gn_act_q[l]);
      rnd4_d[l]  = (prod3_q[l] + RND_HALF) >>> SHIFT;
      y5_d[l]    = y5_q[l];
      if (vld_q[3]) begin
        if (rnd4_q[l] > MAXV) begin
          y5_d[l] = MAXV[OUT_W-1:0];
        end else if (rnd4_q[l] < MINV) begin
          y5_d[l] = MINV[OUT_W-1:0];
        end else begin
          y5_d[l] = rnd4_q[l][OUT_W-1:0];
        end
      end
    end
    vld_d = {vld_q[3:0], in_valid};
    stb_d = {stb_q[3:0], stb_start};
  end

  // Commit FSM: the active set only changes while nothing is in flight.
  always_comb begin
    pipe_idle = !in_valid && (vld_q == 5'd0);
    state_d   = state_q;
    do_copy   = 1'b0;
    case (state_q)
      IDLE: begin
        if (cfg_commit) begin
          if (pipe_idle) begin
            do_copy = 1'b1;
          end else begin
            state_d = PENDING;
          end
        end
      end
      PENDING: begin
        if (pipe_idle) begin
          do_copy = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Coefficient banks: copy reads the shadow before this cycle's write lands.
  always_comb begin
    for (int l = 0; l < L; l++) begin
      off_sh_d[l]  = off_sh_q[l];
      gn_sh_d[l]   = gn_sh_q[l];
      off_act_d[l] = do_copy ? off_sh_q[l] : off_act_q[l];
      gn_act_d[l]  = do_copy ? gn_sh_q[l]  : gn_act_q[l];
      if (cfg_we && (cfg_lane == AW'(l))) begin
        if (cfg_sel) begin
          gn_sh_d[l] = cfg_data[COEF_W-1:0];
        end else begin
          off_sh_d[l] = cfg_data;
        end
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q   <= '0;
      stb_q   <= '0;
      state_q <= IDLE;
      for (int l = 0; l < L; l++) begin
        x1_q[l]      <= '0;
        sum2_q[l]    <= '0;
        prod3_q[l]   <= '0;
        rnd4_q[l]    <= '0;
        y5_q[l]      <= '0;
        off_sh_q[l]  <= '0;
        off_act_q[l] <= '0;
        gn_sh_q[l]   <= GAIN_ONE;
        gn_act_q[l]  <= GAIN_ONE;
      end
    end else begin
      vld_q   <= vld_d;
      stb_q   <= stb_d;
      state_q <= state_d;
      for (int l = 0; l < L; l++) begin
        x1_q[l]      <= x1_d[l];
        sum2_q[l]    <= sum2_d[l];
        prod3_q[l]   <= prod3_d[l];
        rnd4_q[l]    <= rnd4_d[l];
        y5_q[l]      <= y5_d[l];
        off_sh_q[l]  <= off_sh_d[l];
        off_act_q[l] <= off_act_d[l];
        gn_sh_q[l]   <= gn_sh_d[l];
        gn_act_q[l]  <= gn_act_d[l];
      end
    end
  end

  // Output packing.
  always_comb begin
    for (int l = 0; l < L; l++) begin
      out_data[l*OUT_W +: OUT_W] = y5_q[l];
    end
    out_valid       = vld_q[4];
    NN_startTrigger = stb_q[4];
    cfg_pending     = (state_q == PENDING);
  end

`ifdef IQ_NORM_SAT_COUNT_EN
  logic [15:0] sat_cnt_q, sat_cnt_d;
  logic        any_sat;

  // Saturation event counter: sticky at all-ones, clear has priority.
  always_comb begin
    any_sat = 1'b0;
    for (int l = 0; l < L; l++) begin
      if (vld_q[3] && ((rnd4_q[l] > MAXV) || (rnd4_q[l] < MINV))) begin
        any_sat = 1'b1;
      end
    end
    sat_cnt_d = sat_cnt_q;
    if (sat_clr) begin
      sat_cnt_d = '0;
    end else if (any_sat && (sat_cnt_q != 16'hFFFF)) begin
      sat_cnt_d = sat_cnt_q + 16'd1;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sat_cnt_q <= '0;
    end else begin
      sat_cnt_q <= sat_cnt_d;
    end
  end

  assign sat_count = sat_cnt_q;
`endif

endmodule

// File: tb/tb_iq_norm_pipe.sv
// tb/tb_iq_norm_pipe.sv - scoreboard bench for iq_norm_pipe with arithmetic reference model
module tb_iq_norm_pipe;
  localparam int N_CH = 3, L = 6, IN_W = 32, OUT_W = 18, COEF_W = 18, SHIFT = 16, AW = 3;

  logic                  clk, rst_n, in_valid, stb_start;
  logic [L*IN_W-1:0]     in_data;
  logic                  out_valid, NN_startTrigger;
  logic [L*OUT_W-1:0]    out_data;
  logic                  cfg_we, cfg_sel, cfg_commit, cfg_pending;
  logic [AW-1:0]         cfg_lane;
  logic [IN_W-1:0]       cfg_data;
`ifdef IQ_NORM_SAT_COUNT_EN
  logic [15:0]           sat_count;
  logic                  sat_clr;
  int                    m_sat;
`endif

  iq_norm_pipe #(.N_CH(N_CH), .IN_W(IN_W), .OUT_W(OUT_W), .COEF_W(COEF_W),
                 .SHIFT(SHIFT), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .stb_start(stb_start), .out_valid(out_valid), .out_data(out_data),
    .NN_startTrigger(NN_startTrigger), .cfg_we(cfg_we), .cfg_sel(cfg_sel),
    .cfg_lane(cfg_lane), .cfg_data(cfg_data), .cfg_commit(cfg_commit),
    .cfg_pending(cfg_pending)
`ifdef IQ_NORM_SAT_COUNT_EN
    , .sat_count(sat_count), .sat_clr(sat_clr)
`endif
  );

  typedef struct {
    int                 c;
    logic [L*OUT_W-1:0] d;
    bit                 sat;
  } exp_t;

  exp_t               exp_q[$];
  int                 trig_q[$];
  int                 cyc = 0;
  int                 n_checks = 0, n_fail = 0;
  bit                 mon_en = 0;
  longint             m_off_sh[L], m_off_act[L], m_gn_sh[L], m_gn_act[L];
  bit                 m_pending;
  int                 last_issue;
  logic [L*OUT_W-1:0] last_d;
  int                 x_in[L];

  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [127:0] a, input logic [127:0] e);
    n_checks++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, a, e, cyc);
    end
  endtask

  // y = sat(floor((x + off) * g / 2^SHIFT + 1/2))
  function automatic longint norm(input longint x, input longint off, input longint g,
                                  output bit s);
    longint p, r, mx, mn;
    p  = (x + off) * g;
    r  = (p + (64'sd1 <<< (SHIFT - 1))) >>> SHIFT;
    mx = (64'sd1 <<< (OUT_W - 1)) - 1;
    mn = -(64'sd1 <<< (OUT_W - 1));
    s  = 1'b0;
    if (r > mx) begin r = mx; s = 1'b1; end
    else if (r < mn) begin r = mn; s = 1'b1; end
    return r;
  endfunction

  task automatic model_coef_reset();
    for (int l = 0; l < L; l++) begin
      m_off_sh[l] = 0; m_off_act[l] = 0;
      m_gn_sh[l] = 64'sd1 <<< SHIFT; m_gn_act[l] = 64'sd1 <<< SHIFT;
    end
    m_pending  = 0;
    last_issue = -100;
  endtask

  // One input cycle: drive at the falling edge, update the reference model.
  task automatic step(input bit iv, input bit stb, input bit we, input bit sel,
                      input int lane, input int data, input bit commit);
    exp_t                     e;
    bit                       s, any, idle, do_copy;
    longint                   v;
    logic signed [COEF_W-1:0] g18;
    @(negedge clk);
    check("cfg_pending", cfg_pending, m_pending);
    rst_n = 1; in_valid = iv; stb_start = stb; cfg_we = we; cfg_sel = sel;
    cfg_lane = lane[AW-1:0]; cfg_data = data; cfg_commit = commit;
    for (int l = 0; l < L; l++) in_data[l*IN_W +: IN_W] = x_in[l];
    if (iv) begin
      last_issue = cyc;
      any = 0;
      for (int l = 0; l < L; l++) begin
        v = norm(longint'(x_in[l]), m_off_act[l], m_gn_act[l], s);
        e.d[l*OUT_W +: OUT_W] = OUT_W'(v);
        any |= s;
      end
      e.c = cyc + 5; e.sat = any;
      exp_q.push_back(e);
    end
    if (stb) trig_q.push_back(cyc + 5);
    idle    = (cyc - last_issue) >= 6;
    do_copy = idle && (m_pending || commit);
    if (do_copy) begin
      for (int l = 0; l < L; l++) begin
        m_off_act[l] = m_off_sh[l]; m_gn_act[l] = m_gn_sh[l];
      end
    end
    if (we && lane < L) begin
      if (sel) begin g18 = data[COEF_W-1:0]; m_gn_sh[lane] = g18; end
      else m_off_sh[lane] = longint'(data);
    end
    m_pending = (m_pending || commit) && !do_copy;
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst_n = 0; in_valid = 0; stb_start = 0; cfg_we = 0; cfg_commit = 0;
      while (exp_q.size() > 0 && exp_q[$].c > cyc) void'(exp_q.pop_back());
      while (trig_q.size() > 0 && trig_q[$] > cyc) void'(trig_q.pop_back());
      model_coef_reset();
      last_d = '0;
`ifdef IQ_NORM_SAT_COUNT_EN
      m_sat = 0;
`endif
    end
  endtask

  task automatic rand_lanes(input bit wide);
    for (int l = 0; l < L; l++)
      x_in[l] = (wide && $urandom_range(0, 3) == 0) ? int'($urandom)
                                                    : int'($urandom_range(0, 400000)) - 200000;
  endtask

  // Monitor: pops the scoreboard whenever an output is due.
  initial begin
    exp_t e;
    bit   ev, et;
    forever begin
      @(posedge clk);
      #2;
      if (mon_en) begin
        ev = exp_q.size() > 0 && exp_q[0].c == cyc;
        check("out_valid", out_valid, ev);
        if (ev) begin
          e = exp_q.pop_front();
          check("out_data", out_data, e.d);
          last_d = e.d;
`ifdef IQ_NORM_SAT_COUNT_EN
          if (e.sat && m_sat < 16'hFFFF) m_sat++;
`endif
        end else begin
          check("out_hold", out_data, last_d);
        end
        et = trig_q.size() > 0 && trig_q[0] == cyc;
        check("nn_trigger", NN_startTrigger, et);
        if (et) void'(trig_q.pop_front());
`ifdef IQ_NORM_SAT_COUNT_EN
        check("sat_count", sat_count, m_sat);
`endif
      end
    end
  end

  initial begin
    rst_n = 0; in_valid = 0; stb_start = 0; in_data = '0; cfg_we = 0; cfg_sel = 0;
    cfg_lane = '0; cfg_data = '0; cfg_commit = 0;
    for (int l = 0; l < L; l++) x_in[l] = 0;
`ifdef IQ_NORM_SAT_COUNT_EN
    sat_clr = 0;
`endif
    do_reset(3);
    mon_en = 1;
    idle_n(3);

    // Unity path
    x_in[0] = 1000; x_in[1] = -1000;
    step(1, 1, 0, 0, 0, 0, 0);
    idle_n(7);

    // Offset -500, gain 0.5 on lane 0, committed while idle
    step(0, 0, 1, 0, 0, -500, 0);
    step(0, 0, 1, 1, 0, 32'h8000, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    x_in[0] = 1501;  step(1, 0, 0, 0, 0, 0, 0);
    x_in[0] = -1501; step(1, 0, 0, 0, 0, 0, 0);
    idle_n(7);

    // Saturation at unity gain
    step(0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 1, 1, 0, 32'h10000, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    x_in[0] = 200000;  step(1, 0, 0, 0, 0, 0, 0);
    x_in[0] = -200000; step(1, 0, 0, 0, 0, 0, 0);
    idle_n(7);

    // Write coinciding with an idle commit copy, then out-of-range lane writes
    step(0, 0, 1, 0, 1, 7, 1);
    x_in[1] = 100; step(1, 0, 0, 0, 0, 0, 0);
    idle_n(6);
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 1, 0, 6, 12345, 0);
    step(0, 0, 1, 1, 7, 32'h3000, 1);
    rand_lanes(0); step(1, 0, 0, 0, 0, 0, 0);
    idle_n(7);

    // Deferred commit during a 10-sample stream
    step(0, 0, 1, 1, 2, 32'h4000, 0);
    for (int i = 0; i < 10; i++) begin
      rand_lanes(0);
      step(1, i == 0, 0, 0, 0, 0, i == 3);
    end
    idle_n(8);
    rand_lanes(0); step(1, 0, 0, 0, 0, 0, 0);
    idle_n(7);

    // Trigger with gaps between samples
    for (int i = 0; i < 12; i++) begin
      rand_lanes(0);
      step(i % 3 != 1, i == 0, 0, 0, 0, 0, 0);
    end
    idle_n(7);

    // Reset with 3 samples in flight and a commit pending
    step(0, 0, 1, 0, 3, 999, 0);
    for (int i = 0; i < 3; i++) begin
      rand_lanes(0);
      step(1, i == 0, 0, 0, 0, 0, i == 1);
    end
    do_reset(1);
    idle_n(7);
    rand_lanes(0); step(1, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    idle_n(7);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      bit iv, we, sel;
      int data;
      rand_lanes(1);
      iv  = $urandom_range(0, 9) < 6;
      we  = $urandom_range(0, 4) == 0;
      sel = $urandom_range(0, 1);
      if (sel) data = ($urandom_range(0, 7) == 0) ? int'($urandom) : int'($urandom_range(0, 131072));
      else     data = ($urandom_range(0, 7) == 0) ? int'($urandom) : int'($urandom_range(0, 4000)) - 2000;
      if ($urandom_range(0, 9) == 0) idle_n($urandom_range(6, 9));
      step(iv, $urandom_range(0, 9) == 0, we, sel, $urandom_range(0, 7), data,
           $urandom_range(0, 14) == 0);
    end
    idle_n(10);

    check("scoreboard_empty", exp_q.size(), 0);
    check("trigger_queue_empty", trig_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/iq_norm_pipe.md
Name: iq_norm_pipe

Overview:
- Parametrised multi-channel I/Q normaliser between the readout accumulators and the NN inference core.
- Per lane it computes y = sat(round(((x + offset) * gain) >>> SHIFT)).
- Offset and gain are runtime-programmable per lane through double-buffered coefficients.
- Forwards the NN start trigger aligned to the first normalised sample. Fixed-latency streaming pipeline, no back-pressure.

Parameters:
- N_CH, 1: number of I/Q channel pairs; lanes L = 2*N_CH (lane 2k = I of ch k, lane 2k+1 = Q).
- IN_W, 32: signed input sample width per lane.
- OUT_W, 18: signed output width per lane.
- COEF_W, 18: signed gain width.
- SHIFT, 16: fractional bits of gain; gain 1.0 = 2^SHIFT. Must be >=1.
- AW, clog2(L) (min 1): coefficient lane address width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  input lanes valid this cycle.
- in_data  in  L*IN_W  lane l at [l*IN_W +: IN_W], signed.
- stb_start  in  1  start strobe accompanying the first sample of a frame.
- out_valid  out  1  output lanes valid.
- out_data  out  L*OUT_W  lane l at [l*OUT_W +: OUT_W], signed.
- NN_startTrigger  out  1  stb_start delayed to align with out_valid.
- cfg_we  in  1  write shadow coefficient.
- cfg_sel  in  1  0 = offset, 1 = gain.
- cfg_lane  in  AW  target lane; values >= L ignored.
- cfg_data  in  IN_W  offset (IN_W signed) or gain (low COEF_W bits, signed).
- cfg_commit  in  1  request shadow -> active copy.
- cfg_pending  out  1  commit requested but not yet applied.

Behaviour:
- Reset (rst_n=0 at posedge clk): all pipeline valids, out_valid, NN_startTrigger and cfg_pending = 0; out_data = 0.
- Reset coefficients: shadow and active offset = 0; gain = 2^SHIFT (unity).
- Reset mid-stream discards all in-flight samples.
- Pipeline, 5 cycles, in_valid at cycle t -> out_valid at t+5:
  - S1: register in_data, in_valid, stb_start.
  - S2: sum = sext(x) + sext(offset), IN_W+1 bits, no overflow.
  - S3: prod = sum * gain, signed, IN_W+1+COEF_W bits.
  - S4: rnd = (prod + 2^(SHIFT-1)) >>> SHIFT, i.e. round half toward +inf.
  - S5: saturate rnd to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- Data registers advance every cycle. Lanes with valid=0 carry don't-care data; out_data holds its last valid value while out_valid=0.
- NN_startTrigger = stb_start delayed exactly 5 cycles, independent of in_valid.
- Coefficient writes:
  - cfg_we writes the shadow register only; active coefficients never change from a write.
  - Writes with cfg_lane >= L have no effect.
- Commit FSM, states IDLE / PENDING:
  - IDLE + cfg_commit: if the S1..S5 valids and in_valid are all 0 this cycle, copy shadow -> active at this edge and stay IDLE. Otherwise go to PENDING, cfg_pending=1.
  - PENDING: on the first cycle with all pipeline valids and in_valid = 0, copy and return to IDLE, cfg_pending=0.
  - cfg_commit while PENDING: no extra effect.
  - Guarantees every sample uses one coherent coefficient set.
- Simultaneous cfg_we and a commit copy in the same cycle: the copy takes the pre-write shadow value; the new write stays in shadow.
- Continuous in_valid=1 holds a commit pending indefinitely. This is documented, not an error.

Optional Feature:
- Macro: IQ_NORM_SAT_COUNT_EN.
- Defined adds port sat_count (out, 16) and sat_clr (in, 1).
- sat_count increments by 1 per output cycle where any lane saturated. It sticks at 0xFFFF and clears to 0 on reset or sat_clr.
- sat_clr in the same cycle as an increment wins (result 0).
- Undefined: the ports and counter are absent and behaviour is otherwise identical.

Test Plan:
- Unity path: N_CH=1, default coefs; I=1000, Q=-1000 with in_valid at t0 -> out I=1000, Q=-1000, out_valid exactly at t0+5.
- Offset+gain: lane0 offset=-500, gain=0x8000 (0.5), committed while idle; I=1501 -> (1001*0.5)=500.5 rounds to 501. I=-1501 -> -1000.5 rounds to -1000.
- Saturation: gain=2^SHIFT, I=200000 -> 131071; I=-200000 -> -131072. With IQ_NORM_SAT_COUNT_EN, sat_count=2.
- Deferred commit:
  - Stream 10 samples; assert cfg_commit at sample 3 -> cfg_pending=1 until the pipeline drains.
  - All 10 outputs use the old coefs; the next sample uses the new coefs; cfg_pending falls on the copy cycle.
- Trigger alignment: stb_start with first in_valid, gaps inserted -> NN_startTrigger high in the same cycle as the first out_valid, one cycle wide.
- Reset mid-stream: drive rst_n=0 with 3 samples in flight -> no out_valid afterwards, coefs back to offset 0 / unity, cfg_pending=0.
